// File: rtl/reg_alu_exec_seq.sv
// Self-sequencing execute unit: register file, ALU and writeback behind a valid/ready handshake.
// Define REG_SEED_EN to reset R[i] to i instead of 0.
module reg_alu_exec_seq #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_CNT = 32,
    parameter int unsigned REG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [REG_AW-1:0] op_rs,
    input  logic [REG_AW-1:0] op_rt,
    input  logic [REG_AW-1:0] op_rd,
    input  logic [DATA_W-1:0] op_imm,
    input  logic              op_alusrc,
    input  logic [3:0]        op_aluctrl,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_overflow,
    input  logic [REG_AW-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0100;
    localparam logic [3:0] AluOr  = 4'b0101;
    localparam logic [3:0] AluXor = 4'b0110;
    localparam logic [3:0] AluNor = 4'b0111;
    localparam logic [3:0] AluSlt = 4'b1000;

    state_e r_state;
    state_e w_state_d;

    logic [DATA_W-1:0] r_regs [REG_CNT];

    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_imm;
    logic              r_alusrc;
    logic [3:0]        r_ctrl;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_res_data;
    logic              r_res_zero;
    logic              r_res_ovf;

    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_slt;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_ovf;

    // r0 is never written, but the read mux makes the hardwiring explicit.
    assign w_rdata_a = (r_rs == '0) ? '0 : r_regs[r_rs];
    assign w_rdata_b = (r_rt == '0) ? '0 : r_regs[r_rt];
    assign dbg_rdata = (dbg_raddr == '0) ? '0 : r_regs[dbg_raddr];

    assign w_sum  = r_a + r_b;
    assign w_diff = r_a - r_b;
    assign w_slt  = $signed(r_a) < $signed(r_b);

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        unique case (r_ctrl)
            AluAdd: begin
                w_alu_res = w_sum;
                w_alu_ovf = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_sum[DATA_W-1] != r_a[DATA_W-1]);
            end
            AluSub: begin
                w_alu_res = w_diff;
                w_alu_ovf = (r_a[DATA_W-1] != r_b[DATA_W-1]) && (w_diff[DATA_W-1] != r_a[DATA_W-1]);
            end
            AluAnd:  w_alu_res = r_a & r_b;
            AluOr:   w_alu_res = r_a | r_b;
            AluXor:  w_alu_res = r_a ^ r_b;
            AluNor:  w_alu_res = ~(r_a | r_b);
            AluSlt:  w_alu_res = {{(DATA_W-1){1'b0}}, w_slt};
            default: begin
                w_alu_res = '0;
                w_alu_ovf = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                op_ready = 1'b1;
                if (op_valid) w_state_d = StRead;
            end
            StRead: w_state_d = StExec;
            StExec: w_state_d = StWb;
            StWb: begin
                res_valid = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_imm      <= '0;
            r_alusrc   <= 1'b0;
            r_ctrl     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_res_data <= '0;
            r_res_zero <= 1'b0;
            r_res_ovf  <= 1'b0;
            for (int i = 0; i < int'(REG_CNT); i++) begin
`ifdef REG_SEED_EN
                r_regs[i] <= DATA_W'(i);
`else
                r_regs[i] <= '0;
`endif
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (op_valid) begin
                        r_rs     <= op_rs;
                        r_rt     <= op_rt;
                        r_rd     <= op_rd;
                        r_imm    <= op_imm;
                        r_alusrc <= op_alusrc;
                        r_ctrl   <= op_aluctrl;
                    end
                end
                StRead: begin
                    r_a <= w_rdata_a;
                    r_b <= r_alusrc ? r_imm : w_rdata_b;
                end
                // Result lands in the output holding registers so it is visible throughout WB.
                StExec: begin
                    r_res_data <= w_alu_res;
                    r_res_zero <= (w_alu_res == '0);
                    r_res_ovf  <= w_alu_ovf;
                end
                StWb: begin
                    if (r_rd != '0) r_regs[r_rd] <= r_res_data;
                end
                default: ;
            endcase
        end
    end

    assign res_data     = r_res_data;
    assign res_zero     = r_res_zero;
    assign res_overflow = r_res_ovf;

endmodule

// File: tb/tb_reg_alu_exec_seq.sv
// Directed bench for reg_alu_exec_seq: hand-computed vectors, latency, handshake and reset abort.
module tb_reg_alu_exec_seq;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_CNT = 32;
    localparam int unsigned REG_AW  = 5;

`ifdef REG_SEED_EN
    localparam bit Seeded = 1'b1;
`else
    localparam bit Seeded = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              op_valid;
    logic              op_ready;
    logic [REG_AW-1:0] op_rs;
    logic [REG_AW-1:0] op_rt;
    logic [REG_AW-1:0] op_rd;
    logic [DATA_W-1:0] op_imm;
    logic              op_alusrc;
    logic [3:0]        op_aluctrl;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_zero;
    logic              res_overflow;
    logic [REG_AW-1:0] dbg_raddr;
    logic [DATA_W-1:0] dbg_rdata;

    int n_total;
    int n_bad;

    reg_alu_exec_seq #(
        .DATA_W (DATA_W),
        .REG_CNT(REG_CNT),
        .REG_AW (REG_AW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_rs       (op_rs),
        .op_rt       (op_rt),
        .op_rd       (op_rd),
        .op_imm      (op_imm),
        .op_alusrc   (op_alusrc),
        .op_aluctrl  (op_aluctrl),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_zero    (res_zero),
        .res_overflow(res_overflow),
        .dbg_raddr   (dbg_raddr),
        .dbg_rdata   (dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] rst_val(input int idx);
        return Seeded ? 32'(idx) : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Called at #1 after an edge with the unit idle; returns at #1 after the edge that re-enters idle.
    task automatic run_op(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] imm, input logic alusrc,
                          input logic [3:0] ctrl, output logic [31:0] wb_dbg);
        int lat;
        int pulses;
        int ready_hi;
        dbg_raddr  = rd;
        op_rs      = rs;
        op_rt      = rt;
        op_rd      = rd;
        op_imm     = imm;
        op_alusrc  = alusrc;
        op_aluctrl = ctrl;
        op_valid   = 1'b1;
        @(posedge clk);
        #1;
        op_valid   = 1'b0;
        op_rs      = 5'($urandom);
        op_rt      = 5'($urandom);
        op_rd      = 5'($urandom);
        op_imm     = $urandom;
        op_alusrc  = 1'($urandom);
        op_aluctrl = 4'($urandom);
        lat = 0;
        pulses = 0;
        ready_hi = 0;
        wb_dbg = 'x;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (k <= 3 && op_ready) ready_hi++;
            if (res_valid) begin
                pulses++;
                lat = k;
                wb_dbg = dbg_rdata;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_busy"}, 32'(ready_hi), 32'd0);
        check({tag, "_ready_after"}, 32'(op_ready), 32'd1);
    endtask

    logic [31:0] wbd;
    int acc;
    int last_imm;
    int pulses;

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rst        = 1'b1;
        op_valid   = 1'b0;
        op_rs      = '0;
        op_rt      = '0;
        op_rd      = '0;
        op_imm     = '0;
        op_alusrc  = 1'b0;
        op_aluctrl = '0;
        dbg_raddr  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_ready", 32'(op_ready), 32'd1);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_data", res_data, 32'h0);
        check("rst_zero", 32'(res_zero), 32'd0);
        check("rst_ovf", 32'(res_overflow), 32'd0);
        dbg_raddr = 5'd7;
        #1;
        check("rst_r7", dbg_rdata, rst_val(7));
        dbg_raddr = 5'd0;
        #1;
        check("rst_r0", dbg_rdata, 32'h0);

        run_op("or_r1", 5'd0, 5'd0, 5'd1, 32'h7FFF_FFFF, 1'b1, 4'b0101, wbd);
        check("or_r1_data", res_data, 32'h7FFF_FFFF);
        check("or_r1_dbg", dbg_rdata, 32'h7FFF_FFFF);

        run_op("or_r2", 5'd0, 5'd0, 5'd2, 32'h1, 1'b1, 4'b0101, wbd);
        check("or_r2_data", res_data, 32'h1);

        run_op("add_ovf", 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 4'b0000, wbd);
        check("add_ovf_data", res_data, 32'h8000_0000);
        check("add_ovf_ovf", 32'(res_overflow), 32'd1);
        check("add_ovf_zero", 32'(res_zero), 32'd0);
        check("add_ovf_wb_old", wbd, rst_val(3));
        check("add_ovf_r3", dbg_rdata, 32'h8000_0000);

        run_op("sub_r0", 5'd2, 5'd2, 5'd0, 32'h0, 1'b0, 4'b0001, wbd);
        check("sub_r0_data", res_data, 32'h0);
        check("sub_r0_zero", 32'(res_zero), 32'd1);
        check("sub_r0_ovf", 32'(res_overflow), 32'd0);
        check("sub_r0_dbg", dbg_rdata, 32'h0);

        run_op("or_r4", 5'd0, 5'd0, 5'd4, 32'hFFFF_FFFF, 1'b1, 4'b0101, wbd);
        run_op("slt", 5'd4, 5'd2, 5'd6, 32'h0, 1'b0, 4'b1000, wbd);
        check("slt_data", res_data, 32'h1);
        check("slt_r6", dbg_rdata, 32'h1);

        run_op("illegal", 5'd1, 5'd2, 5'd7, 32'h0, 1'b0, 4'b1111, wbd);
        check("illegal_data", res_data, 32'h0);
        check("illegal_zero", 32'(res_zero), 32'd1);
        check("illegal_ovf", 32'(res_overflow), 32'd0);

        run_op("sub_ovf", 5'd3, 5'd2, 5'd8, 32'h0, 1'b0, 4'b0001, wbd);
        check("sub_ovf_data", res_data, 32'h7FFF_FFFF);
        check("sub_ovf_ovf", 32'(res_overflow), 32'd1);

        run_op("xor", 5'd1, 5'd0, 5'd10, 32'hFFFF_FFFF, 1'b1, 4'b0110, wbd);
        check("xor_data", res_data, 32'h8000_0000);
        check("xor_ovf", 32'(res_overflow), 32'd0);
        run_op("nor", 5'd0, 5'd0, 5'd11, 32'h0, 1'b0, 4'b0111, wbd);
        check("nor_data", res_data, 32'hFFFF_FFFF);
        run_op("and", 5'd4, 5'd0, 5'd12, 32'h0000_00F0, 1'b1, 4'b0100, wbd);
        check("and_data", res_data, 32'h0000_00F0);

        // op_valid held high with a new immediate every cycle.
        acc = 0;
        last_imm = -1;
        dbg_raddr  = 5'd9;
        op_rs      = 5'd2;
        op_rd      = 5'd9;
        op_alusrc  = 1'b1;
        op_aluctrl = 4'b0000;
        op_valid   = 1'b1;
        for (int c = 0; c < 16; c++) begin
            op_imm = 32'(c);
            #1;
            if (op_ready) begin
                acc++;
                last_imm = c;
            end
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
        check("stream_accepts", 32'(acc), 32'd4);
        check("stream_data", res_data, 32'(last_imm + 1));
        check("stream_r9", dbg_rdata, 32'd13);
        check("stream_ready", 32'(op_ready), 32'd1);

        // Reset during EXEC aborts the write to r5.
        pulses = 0;
        dbg_raddr  = 5'd5;
        op_rs      = 5'd1;
        op_rt      = 5'd2;
        op_rd      = 5'd5;
        op_alusrc  = 1'b0;
        op_aluctrl = 4'b0000;
        op_valid   = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        if (res_valid) pulses++;
        @(posedge clk);
        #1;
        if (res_valid) pulses++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        if (res_valid) pulses++;
        rst = 1'b0;
        check("abort_ready", 32'(op_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (res_valid) pulses++;
        end
        check("abort_pulses", 32'(pulses), 32'd0);
        check("abort_r5", dbg_rdata, rst_val(5));
        check("abort_data", res_data, 32'h0);
        dbg_raddr = 5'd3;
        #1;
        check("abort_r3", dbg_rdata, rst_val(3));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_alu_exec_seq.md
Name: reg_alu_exec_seq

Overview:
- Parametrised, self-sequencing execute unit: internal register file + ALU + writeback behind a valid/ready micro-op handshake.
- Replaces hand-driven regsFile/alu/regWrite sequencing with a 4-state FSM.
- Generalised in data width and register count.
- Adds SUB/XOR/NOR/SLT, r0 hardwiring and a debug read port.
- Sits between a future decode stage and dataMem.

Parameters:
DATA_W, 32, datapath and register width in bits (>=8)
REG_CNT, 32, number of architectural registers (power of 2, >=4)
REG_AW, 5, register index width; must equal log2(REG_CNT)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
op_valid  input  1  micro-op present
op_ready  output  1  unit can accept a micro-op
op_rs  input  REG_AW  source register 1
op_rt  input  REG_AW  source register 2
op_rd  input  REG_AW  destination register
op_imm  input  DATA_W  immediate, used as-is (no extension)
op_alusrc  input  1  0: operand B = R[rt]; 1: operand B = op_imm
op_aluctrl  input  4  ALU operation code
res_valid  output  1  one-cycle pulse, result committed
res_data  output  DATA_W  ALU result of the completed op
res_zero  output  1  res_data == 0
res_overflow  output  1  signed overflow of the completed op
dbg_raddr  input  REG_AW  debug read index
dbg_rdata  output  DATA_W  combinational R[dbg_raddr]

Behaviour:
- Reset: FSM to IDLE; op_ready=1; res_valid=0; res_data=0; res_zero=0; res_overflow=0; all registers cleared to 0, except as described under Optional Feature.
- Handshake: a micro-op is accepted on a rising edge where op_valid && op_ready.
  - op_ready=1 only in IDLE.
  - On accept, all op_* fields are latched; later input changes are ignored.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE, one cycle per state. No stalls.
  - READ: latch A=R[rs], B=(alusrc ? imm : R[rt]).
  - EXEC: compute result/zero/overflow into holding regs.
  - WB: write R[rd], drive outputs, res_valid=1 for exactly this cycle.
- Latency: accept at edge N -> res_valid high in cycle N+3 -> next accept possible at edge N+4. Throughput is 1 op per 4 cycles.
- res_data/res_zero/res_overflow update in WB and hold until the next WB or reset.
- ALU codes:
  - 0000 ADD; 0001 SUB (A-B).
  - 0100 AND; 0101 OR; 0110 XOR; 0111 NOR.
  - 1000 SLT: signed, result 1 or 0, zero-extended to DATA_W.
  - Any other code: result 0, overflow 0.
- Arithmetic: modulo 2^DATA_W.
  - ADD overflow = operands share a sign and the result sign differs.
  - SUB overflow = operand signs differ and the result sign differs from A.
  - Overflow is 0 for all other ops.
  - Overflow does not suppress writeback.
- r0: always reads 0. A write with rd=0 is discarded, but res_data still reports the computed value.
- rs==rt and rd==rs/rt are legal; operands are captured in READ, so no hazard arises.
- dbg_rdata is combinational. During WB it shows the old value; the new value is visible from the following cycle.
- Reset mid-operation (READ/EXEC/WB): op is aborted with no register write and no res_valid pulse. Registers are re-initialised per reset rules.

Optional Feature:
- Macro: REG_SEED_EN.
- Defined: reset loads R[i]=i for every i in 1..REG_CNT-1; R[0] remains 0.
- Undefined: reset clears all registers to 0.
- FSM and ALU behaviour are identical in both builds.

Test Plan:
- REG_SEED_EN defined, rst 2 cycles; op ADD rs=1 rt=2 rd=10 alusrc=0 -> res_valid exactly 3 cycles after accept, res_data=3, zero=0; then dbg_raddr=10 reads 3; op_ready low for cycles N+1..N+3.
- OR rs=4 imm=0x00000001 alusrc=1 rd=11 (seeded) -> res_data=0x00000005; then ADD rs=10 rt=11 rd=25 -> res_data=0x00000008, R[25]=8.
- REG_SEED_EN undefined: OR rs=0 imm=0x7FFFFFFF rd=1; OR rs=0 imm=1 rd=2; ADD rs=1 rt=2 rd=3 -> res_data=0x80000000, overflow=1, R[3]=0x80000000.
- SUB rs=2 rt=2 rd=0 -> res_data=0, zero=1; dbg R[0]=0. SLT with A=0xFFFFFFFF, B=1 -> res_data=1. Illegal code 1111 -> res_data=0.
- op_valid held high continuously with changing fields -> exactly one accept per 4 cycles; fields changed after accept do not affect the result.
- rst asserted in EXEC of ADD rd=5 -> no res_valid pulse, R[5] equals reset value, op_ready=1 in the cycle after reset deasserts.
